alu_arbiter: RTL and testbench

Shares a single 8-bit ALU datapath between two requesters. Each requester uses its own valid/ready request channel. A round-robin arbiter grants one request at a time and registers its operands. The block then runs one ALU evaluation and returns the result, flags and requester ID on a shared valid/ready response channel. It sits between the two operand-issuing units and the ALU (add, sub, mul, div, and, or, not, xor; 3-bit opcode).

---
 rtl/alu_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one 8-bit ALU between two requesters. A round-robin arbiter
//   accepts one request at a time in IDLE, the latched operands are
//   evaluated for one cycle in EXEC, and the registered response is held
//   in RESP until the consumer takes it.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req{0,1}_valid/_ready         request handshakes (ready is combinational)
//   req{0,1}_op/_a/_b             opcode and operands
//   rsp_valid/rsp_ready           response handshake
//   rsp_id                        requester that issued the operation
//   rsp_result/_carry/_zero/_dz   registered ALU result and flags
//   dz_count                      saturating count of delivered div-by-zero
//   busy                          high whenever not IDLE
module alu_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic        rsp_carry,
  output logic        rsp_zero,
  output logic        rsp_dz,
  output logic [7:0]  dz_count,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_NOT, OP_XOR
  } op_e;

  state_e      state_q;
  logic        prio_q;        // requester that wins the next tie
  logic        id_q;
  op_e         op_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;

  logic        rsp_valid_q;
  logic        rsp_id_q;
  logic [15:0] result_q;
  logic        carry_q;
  logic        zero_q;
  logic        dz_q;
  logic [7:0]  dz_count_q;

  logic        grant0;
  logic        grant1;

  logic [8:0]  sum9;
  logic [15:0] prod;
  logic [7:0]  res8;
  logic [15:0] result_d;
  logic        carry_d;
  logic        zero_d;
  logic        dz_d;

  // Grant depends only on the valids, the tie pointer and the state.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && (!req1_valid || !prio_q)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  always_comb begin
    sum9    = '0;
    res8    = '0;
    carry_d = 1'b0;
    dz_d    = 1'b0;
    prod    = {8'h00, a_q} * {8'h00, b_q};
    case (op_q)
      OP_ADD: begin
        sum9    = {1'b0, a_q} + {1'b0, b_q};
        res8    = sum9[7:0];
        carry_d = sum9[8];
      end
      OP_SUB: begin
        // A + ~B + 1: carry-out set means no borrow
        sum9    = {1'b0, a_q} + {1'b0, ~b_q} + 9'd1;
        res8    = sum9[7:0];
        carry_d = ~sum9[8];
      end
      OP_MUL: res8 = prod[7:0];
      OP_DIV: begin
        if (b_q == '0) begin
          res8 = '1;
          dz_d = 1'b1;
        end else begin
          res8 = a_q / b_q;
        end
      end
      OP_AND: res8 = a_q & b_q;
      OP_OR:  res8 = a_q | b_q;
      OP_NOT: res8 = ~a_q;
      OP_XOR: res8 = a_q ^ b_q;
      default: res8 = '0;
    endcase
    result_d = (op_q == OP_MUL) ? prod : {8'h00, res8};
    zero_d   = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= RR_INIT;
      id_q        <= 1'b0;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      dz_q        <= 1'b0;
      dz_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            id_q    <= grant1;
            op_q    <= grant1 ? op_e'(req1_op) : op_e'(req0_op);
            a_q     <= grant1 ? req1_a : req0_a;
            b_q     <= grant1 ? req1_b : req0_b;
            prio_q  <= grant0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_id_q    <= id_q;
          result_q    <= result_d;
          carry_q     <= carry_d;
          zero_q      <= zero_d;
          dz_q        <= dz_d;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
            if (dz_q && (dz_count_q != '1)) begin
              dz_count_q <= dz_count_q + 8'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = result_q;
  assign rsp_carry  = carry_q;
  assign rsp_zero   = zero_q;
  assign rsp_dz     = dz_q;
  assign dz_count   = dz_count_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Scoreboard bench for alu_arbiter. The driver predicts arbitration and
//   response timing from the handshake rules, pushes the arithmetic result
//   of every accepted request, and a negedge monitor compares the DUT
//   against those expectations.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [2:0]  req0_op = '0;
  logic [7:0]  req0_a = '0;
  logic [7:0]  req0_b = '0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [2:0]  req1_op = '0;
  logic [7:0]  req1_a = '0;
  logic [7:0]  req1_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_id;
  logic [15:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_zero;
  logic        rsp_dz;
  logic [7:0]  dz_count;
  logic        busy;

  alu_arbiter #(.RR_INIT(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .rsp_dz     (rsp_dz),
    .dz_count   (dz_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        id;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        dz;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  // reference model state
  bit   outstanding = 1'b0;
  int   acc_edge = 0;
  int   cyc = 0;
  bit   ptr = 1'b0;
  int   mdz = 0;
  bit   mon_en = 1'b0;
  bit   last_acc = 1'b0;
  bit   exp_r0 = 1'b0;
  bit   exp_r1 = 1'b0;
  bit   exp_rv = 1'b0;
  bit   exp_busy = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  function automatic rsp_t ref_alu(input int id, input int op, input int a, input int b);
    rsp_t r;
    int   v;
    r    = '0;
    r.id = (id != 0);
    v    = 0;
    case (op)
      0: begin v = a + b; r.c = (v > 255); v = v % 256; end
      1: begin r.c = (a < b); v = (a - b + 256) % 256; end
      2: v = a * b;
      3: if (b == 0) begin v = 255; r.dz = 1'b1; end else v = a / b;
      4: v = a & b;
      5: v = a | b;
      6: v = 255 - a;
      default: v = a ^ b;
    endcase
    r.res = v[15:0];
    r.z   = (v == 0);
    return r;
  endfunction

  // One clock cycle: drive inputs, predict this cycle's outputs, advance.
  task automatic step(input int v0, input int o0, input int a0, input int b0,
                      input int v1, input int o1, input int a1, input int b1,
                      input int rr);
    bit g0, g1, hs;
    req0_valid = (v0 != 0); req0_op = o0[2:0]; req0_a = a0[7:0]; req0_b = b0[7:0];
    req1_valid = (v1 != 0); req1_op = o1[2:0]; req1_a = a1[7:0]; req1_b = b1[7:0];
    rsp_ready  = (rr != 0);
    g0 = !outstanding && (v0 != 0) && ((v1 == 0) || (ptr == 1'b0));
    g1 = !outstanding && (v1 != 0) && !g0;
    exp_r0   = g0;
    exp_r1   = g1;
    exp_busy = outstanding;
    exp_rv   = outstanding && (cyc >= acc_edge + 1);
    hs       = exp_rv && (rr != 0);
    last_acc = g0 || g1;
    if (g0) exp_q.push_back(ref_alu(0, o0, a0, b0));
    if (g1) exp_q.push_back(ref_alu(1, o1, a1, b1));
    @(posedge clk);
    #1;
    cyc++;
    if (hs) outstanding = 1'b0;
    if (g0 || g1) begin
      outstanding = 1'b1;
      acc_edge    = cyc;
      ptr         = g0;
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst         = 1'b0;
    outstanding = 1'b0;
    ptr         = 1'b0;
    exp_q.delete();
    mdz         = 0;
    exp_r0 = 1'b0; exp_r1 = 1'b0; exp_rv = 1'b0; exp_busy = 1'b0;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dz_count", dz_count, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_flags", {rsp_carry, rsp_zero, rsp_dz}, 0);
  endtask

  task automatic send(input int id, input int op, input int a, input int b, input int rr);
    for (int i = 0; i < 20; i++) begin
      if (id == 0) step(1, op, a, b, 0, 0, 0, 0, rr);
      else         step(0, 0, 0, 0, 1, op, a, b, rr);
      if (last_acc) break;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (outstanding || exp_q.size() != 0); i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // Monitor: compares handshakes and pops responses as they are delivered.
  always @(negedge clk) begin
    rsp_t e;
    if (mon_en && !rst) begin
      chk("req0_ready", req0_ready, exp_r0);
      chk("req1_ready", req1_ready, exp_r1);
      chk("rsp_valid", rsp_valid, exp_rv);
      chk("busy", busy, exp_busy);
      chk("dz_count", dz_count, mdz);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          e = exp_q[0];
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_carry", rsp_carry, e.c);
          chk("rsp_zero", rsp_zero, e.z);
          chk("rsp_dz", rsp_dz, e.dz);
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            if (e.dz && mdz < 255) mdz++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    do_reset();
    do_reset();
    mon_en = 1'b1;

    // directed operations
    send(0, 0, 200, 100, 1); drain();
    send(1, 1, 3, 5, 1);     drain();
    send(1, 2, 255, 255, 1); drain();

    // both requesters valid every cycle: grants must alternate
    for (int i = 0; i < 12; i++)
      step(1, $urandom % 8, $urandom % 256, $urandom % 256,
           1, $urandom % 8, $urandom % 256, $urandom % 256, 1);
    drain();

    // divide by zero held under back-pressure
    send(0, 3, 9, 0, 0);
    repeat (6) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drain();

    send(0, 4, 8'h0F, 8'hF0, 1); drain();
    send(1, 6, 8'hFF, 0, 1);     drain();

    // random traffic, payload changes while waiting, random back-pressure
    for (int i = 0; i < 400; i++)
      step($urandom % 2, $urandom % 8, $urandom % 256, $urandom % 4 == 0 ? 0 : $urandom % 256,
           $urandom % 2, $urandom % 8, $urandom % 256, $urandom % 256,
           ($urandom % 4) != 0);
    drain();

    // saturate the divide-by-zero counter
    for (int i = 0; i < 930; i++)
      step(1, 3, $urandom % 256, 0, 1, 3, $urandom % 256, 0, 1);
    drain();
    chk("dz_saturated", dz_count, 255);

    // reset while in EXEC, then while in RESP; last grant before reset is req0
    send(0, 3, 1, 0, 0);
    do_reset();
    send(0, 3, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // first tie after reset goes to requester 0
    step(1, 0, 1, 2, 1, 0, 3, 4, 1);
    drain();
    step(1, 7, 5, 6, 1, 7, 7, 8, 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
